// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with a valid/ready handshake, optional two-entry skid
// buffer, synchronous flush to a bubble and a saturating stall counter.
module pipe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 16,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic             accept;
    logic             issue;
    logic [CNT_W-1:0] stallCntQ, stallCntD;

    assign accept = in_valid && in_ready;
    assign issue  = out_valid && out_ready;

    // Counts cycles where the head is blocked downstream; flush does not touch it.
    always_comb begin
        stallCntD = stallCntQ;
        if (out_valid && !out_ready && (stallCntQ != {CNT_W{1'b1}}))
            stallCntD = stallCntQ + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) stallCntQ <= '0;
        else       stallCntQ <= stallCntD;
    end

    assign stall_cnt = stallCntQ;

    if (SKID == 0) begin : g_single
        logic              validQ, validD;
        logic [DATA_W-1:0] dataQ, dataD;
        logic [CTRL_W-1:0] ctrlQ, ctrlD;

        always_comb begin
            validD = validQ;
            dataD  = dataQ;
            ctrlD  = ctrlQ;
            if (flush) begin
                validD = 1'b0;
                dataD  = '0;
                ctrlD  = '0;
            end else if (accept) begin
                validD = 1'b1;
                dataD  = in_data;
                ctrlD  = in_ctrl;
            end else if (issue) begin
                validD = 1'b0;
                dataD  = '0;
                ctrlD  = '0;
            end
        end

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                validQ <= 1'b0;
                dataQ  <= '0;
                ctrlQ  <= '0;
            end else begin
                validQ <= validD;
                dataQ  <= dataD;
                ctrlQ  <= ctrlD;
            end
        end

        assign in_ready  = !validQ || out_ready;
        assign out_valid = validQ;
        assign out_data  = validQ ? dataQ : '0;
        assign out_ctrl  = validQ ? ctrlQ : '0;
        assign occupancy = {1'b0, validQ};
    end else begin : g_skid
        localparam logic [1:0] EMPTY = 2'd0;
        localparam logic [1:0] ONE   = 2'd1;
        localparam logic [1:0] TWO   = 2'd2;

        logic [1:0]        stateQ, stateD;
        logic              inReadyQ, inReadyD;
        logic [DATA_W-1:0] headDataQ, headDataD, skidDataQ, skidDataD;
        logic [CTRL_W-1:0] headCtrlQ, headCtrlD, skidCtrlQ, skidCtrlD;

        // The state code doubles as the entry count; in_ready is precomputed from the next state.
        always_comb begin
            stateD    = stateQ;
            headDataD = headDataQ;
            headCtrlD = headCtrlQ;
            skidDataD = skidDataQ;
            skidCtrlD = skidCtrlQ;
            case (stateQ)
                EMPTY: begin
                    if (accept) begin
                        stateD    = ONE;
                        headDataD = in_data;
                        headCtrlD = in_ctrl;
                    end
                end
                ONE: begin
                    if (accept && issue) begin
                        headDataD = in_data;
                        headCtrlD = in_ctrl;
                    end else if (accept) begin
                        stateD    = TWO;
                        skidDataD = in_data;
                        skidCtrlD = in_ctrl;
                    end else if (issue) begin
                        stateD    = EMPTY;
                        headDataD = '0;
                        headCtrlD = '0;
                    end
                end
                TWO: begin
                    if (issue) begin
                        stateD    = ONE;
                        headDataD = skidDataQ;
                        headCtrlD = skidCtrlQ;
                        skidDataD = '0;
                        skidCtrlD = '0;
                    end
                end
                default: begin
                    stateD    = EMPTY;
                    headDataD = '0;
                    headCtrlD = '0;
                    skidDataD = '0;
                    skidCtrlD = '0;
                end
            endcase
            if (flush) begin
                stateD    = EMPTY;
                headDataD = '0;
                headCtrlD = '0;
                skidDataD = '0;
                skidCtrlD = '0;
            end
            inReadyD = (stateD != TWO);
        end

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                stateQ    <= EMPTY;
                inReadyQ  <= 1'b1;
                headDataQ <= '0;
                headCtrlQ <= '0;
                skidDataQ <= '0;
                skidCtrlQ <= '0;
            end else begin
                stateQ    <= stateD;
                inReadyQ  <= inReadyD;
                headDataQ <= headDataD;
                headCtrlQ <= headCtrlD;
                skidDataQ <= skidDataD;
                skidCtrlQ <= skidCtrlD;
            end
        end

        assign in_ready  = inReadyQ;
        assign out_valid = (stateQ != EMPTY);
        assign out_data  = out_valid ? headDataQ : '0;
        assign out_ctrl  = out_valid ? headCtrlQ : '0;
        assign occupancy = stateQ;
    end

endmodule
